// File: rtl/apb_stall_master_if.sv
// APB3 bus bundle between the stall master and its peripheral slaves.
// Slave i drives PRDATA[32*i +: 32], PREADY[i] and PSLVERR[i].
interface apb_stall_master_if #(
  parameter int NSLV = 4
) ();
  logic [NSLV-1:0]    PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PADDR;
  logic [31:0]        PWDATA;
  logic [32*NSLV-1:0] PRDATA;
  logic [NSLV-1:0]    PREADY;
  logic [NSLV-1:0]    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_stall_master.sv
// APB3 master for the single-cycle core: converts peripheral-window loads/stores
// into APB transfers and holds `stop` high until each transfer completes.
module apb_stall_master #(
  parameter int         NSLV      = 4,
  parameter logic [3:0] PERIPH_HI = 4'h4,
  parameter int         SEL_LSB   = 12,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               stop,
  output logic               bus_err,
  input  logic               err_clr,
  apb_stall_master_if.master apb
);

  localparam int              SW       = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [NSLV-1:0] PSEL_ONE = NSLV'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t         state;
  logic [SW-1:0]  sel;
  logic [7:0]     timer;
  logic [3:0]     idx;
  logic           req;
  logic           bad;
  logic           ready;
  logic           slverr;
  logic           done;
  logic           timeout;
  logic           err_set;

  assign req = (mem_read | mem_write) && (addr[31:28] == PERIPH_HI);

  // A whole nibble is decoded so unpopulated slots are flagged instead of aliasing onto real slaves.
  assign idx = addr[SEL_LSB +: 4];
  assign bad = (idx >= 4'(NSLV));

  assign ready   = apb.PREADY[sel];
  assign slverr  = apb.PSLVERR[sel];
  assign done    = (state == ACCESS) && ready;
  assign timeout = (state == ACCESS) && !ready && (timer == TIMEOUT);
  assign err_set = ((state == IDLE) && req && bad) || (done && slverr) || timeout;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch behind.
    stop  = 1'b0;
    rdata = '0;
    case (state)
      IDLE:   stop = req && !bad;
      SETUP:  stop = 1'b1;
      ACCESS: begin
        stop = !ready && !timeout;
        if (done) begin
          rdata = apb.PRDATA[32*int'(sel) +: 32];
        end else if (timeout) begin
          rdata = 32'hDEAD_BEEF;
        end
      end
      default: ;
    endcase
    // Reset drops any pending request immediately, so the core must not see a stall.
    if (!PRESETn) stop = 1'b0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      sel         <= '0;
      timer       <= '0;
      bus_err     <= 1'b0;
      apb.PSEL    <= '0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register here samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (req && !bad) begin
            apb.PADDR  <= addr;
            apb.PWDATA <= wdata;
            apb.PWRITE <= mem_write;
            apb.PSEL   <= PSEL_ONE << idx;
            sel        <= idx[SW-1:0];
            state      <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          timer       <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (ready || timeout) begin
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (err_set) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_stall_master.sv
// Directed bench for apb_stall_master: each transfer pushes its predicted outcome
// onto a scoreboard, and the observed outcome is compared against it on completion.
module tb_apb_stall_master;

  localparam int NSLV    = 4;
  localparam int TIMEOUT = 255;

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b0;
  logic        mem_read  = 1'b0;
  logic        mem_write = 1'b0;
  logic        err_clr   = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stop;
  logic        bus_err;

  apb_stall_master_if #(.NSLV(NSLV)) apb ();

  apb_stall_master #(
    .NSLV     (NSLV),
    .PERIPH_HI(4'h4),
    .SEL_LSB  (12),
    .TIMEOUT  (8'(TIMEOUT))
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stop     (stop),
    .bus_err  (bus_err),
    .err_clr  (err_clr),
    .apb      (apb)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic            xfer;
    logic [NSLV-1:0] psel;
    logic            pwrite;
    logic [31:0]     paddr;
    logic [31:0]     pwdata;
    logic [31:0]     rdata;
    int              stop_cyc;
    int              pen_cyc;
    logic            bus_err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic err_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Starts just after a rising edge with the DUT in IDLE; returns just after the
  // edge that closes the transfer, with the core strobes dropped.
  task automatic xfer(input string name, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input int wait_cyc, input logic [31:0] prd, input logic slverr);
    exp_t            e;
    exp_t            o;
    int              idx;
    logic            req;
    logic            bad;
    logic            tout;
    logic            fin;
    logic            rd_nz;
    int              acc;
    logic [NSLV-1:0] oh;

    idx  = int'(a[15:12]);
    req  = (rd || wr) && (a[31:28] == 4'h4);
    bad  = (idx >= NSLV);
    tout = (wait_cyc > TIMEOUT);
    e.xfer     = req && !bad;
    e.psel     = e.xfer ? NSLV'(1 << idx) : '0;
    e.pwrite   = wr;
    e.paddr    = a;
    e.pwdata   = d;
    e.stop_cyc = e.xfer ? 2 + (tout ? TIMEOUT : wait_cyc) : 0;
    e.pen_cyc  = e.xfer ? 2 : -1;
    e.rdata    = !e.xfer ? 32'h0 : (tout ? 32'hDEAD_BEEF : prd);
    if ((req && bad) || (e.xfer && (tout || slverr))) err_model = 1'b1;
    e.bus_err  = err_model;
    sb_q.push_back(e);

    oh = e.psel;
    for (int s = 0; s < NSLV; s++) apb.PRDATA[32*s +: 32] = 32'hC0DE_0000 | 32'(s);
    if (e.xfer) apb.PRDATA[32*idx +: 32] = prd;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;

    o.xfer = 1'b0; o.psel = '0; o.pwrite = 1'b0; o.paddr = '0; o.pwdata = '0;
    o.rdata = '0; o.stop_cyc = 0; o.pen_cyc = -1; o.bus_err = 1'b0;
    fin = 1'b0; rd_nz = 1'b0; acc = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      apb.PREADY  = ~oh | ((apb.PENABLE && acc >= wait_cyc) ? oh : '0);
      apb.PSLVERR = slverr ? oh : ~oh;
      if (apb.PENABLE) acc++;
      @(negedge PCLK);
      if (stop) o.stop_cyc++;
      if (apb.PSEL != '0 && o.psel == '0) begin
        o.paddr  = apb.PADDR;
        o.pwdata = apb.PWDATA;
        o.pwrite = apb.PWRITE;
      end
      o.psel = o.psel | apb.PSEL;
      if (apb.PENABLE && o.pen_cyc < 0) o.pen_cyc = c;
      if (stop && rdata != 32'h0) rd_nz = 1'b1;
      if (!stop) begin
        o.rdata = rdata;
        fin = 1'b1;
      end
      @(posedge PCLK);
      #1;
    end
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    apb.PREADY  = '0;
    apb.PSLVERR = '0;
    o.bus_err   = bus_err;

    e = sb_q.pop_front();
    check({name, " completed"}, 32'(fin), 32'h1);
    check({name, " psel"}, 32'(o.psel), 32'(e.psel));
    check({name, " stop_cycles"}, 32'(o.stop_cyc), 32'(e.stop_cyc));
    check({name, " penable_cycle"}, 32'(o.pen_cyc), 32'(e.pen_cyc));
    check({name, " rdata"}, o.rdata, e.rdata);
    check({name, " rdata_zero_while_stalled"}, 32'(rd_nz), 32'h0);
    check({name, " bus_err"}, 32'(o.bus_err), 32'(e.bus_err));
    check({name, " psel_idle_after"}, 32'(apb.PSEL), 32'h0);
    check({name, " penable_idle_after"}, 32'(apb.PENABLE), 32'h0);
    if (e.xfer) begin
      check({name, " paddr"}, o.paddr, e.paddr);
      check({name, " pwdata"}, o.pwdata, e.pwdata);
      check({name, " pwrite"}, 32'(o.pwrite), 32'(e.pwrite));
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge PCLK);
    #1;
    err_clr   = 1'b0;
    err_model = 1'b0;
    check("err_clr", 32'(bus_err), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apb.PRDATA  = '0;
    apb.PREADY  = '0;
    apb.PSLVERR = '0;
    mem_read    = 1'b1;
    addr        = 32'h4000_1000;
    #1;
    check("reset stop", 32'(stop), 32'h0);
    check("reset psel", 32'(apb.PSEL), 32'h0);
    check("reset penable", 32'(apb.PENABLE), 32'h0);
    check("reset pwrite", 32'(apb.PWRITE), 32'h0);
    check("reset paddr", apb.PADDR, 32'h0);
    check("reset pwdata", apb.PWDATA, 32'h0);
    check("reset bus_err", 32'(bus_err), 32'h0);
    mem_read = 1'b0;
    addr     = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    xfer("store_s1", 1'b0, 1'b1, 32'h4000_1004, 32'hA5A5_0001, 0, 32'h0000_1111, 1'b0);
    xfer("load_s2_wait3", 1'b1, 1'b0, 32'h4000_2000, 32'h0, 3, 32'h1234_5678, 1'b0);
    xfer("ram_load", 1'b1, 1'b0, 32'h0000_3000, 32'h0, 0, 32'h0, 1'b0);
    xfer("both_strobes_s3", 1'b1, 1'b1, 32'h4000_3010, 32'h0BAD_F00D, 1, 32'h3333_0000, 1'b0);
    xfer("decode_err", 1'b1, 1'b0, 32'h4000_5000, 32'h0, 0, 32'h0, 1'b0);
    clear_err();

    // Set and clear in the same cycle: the set must win.
    mem_read = 1'b1;
    addr     = 32'h4000_5000;
    err_clr  = 1'b1;
    @(posedge PCLK);
    #1;
    mem_read  = 1'b0;
    err_clr   = 1'b0;
    err_model = 1'b1;
    check("set_beats_clear", 32'(bus_err), 32'h1);
    clear_err();

    xfer("pslverr_s2", 1'b0, 1'b1, 32'h4000_2008, 32'h5555_AAAA, 1, 32'h2222_0000, 1'b1);
    clear_err();
    xfer("timeout_s0", 1'b1, 1'b0, 32'h4000_0000, 32'h0, 1000, 32'h0, 1'b0);
    clear_err();

    xfer("b2b_s0", 1'b0, 1'b1, 32'h4000_0004, 32'h0000_00AA, 0, 32'h0, 1'b0);
    xfer("b2b_s3", 1'b0, 1'b1, 32'h4000_300C, 32'h0000_00BB, 0, 32'h0, 1'b0);

    // Reset in the middle of a stalled ACCESS phase.
    mem_read = 1'b1;
    addr     = 32'h4000_1000;
    apb.PREADY = '0;
    repeat (3) @(posedge PCLK);
    #1;
    check("pre_reset penable", 32'(apb.PENABLE), 32'h1);
    check("pre_reset stop", 32'(stop), 32'h1);
    #2;
    PRESETn = 1'b0;
    #1;
    err_model = 1'b0;
    check("midreset psel", 32'(apb.PSEL), 32'h0);
    check("midreset penable", 32'(apb.PENABLE), 32'h0);
    check("midreset stop", 32'(stop), 32'h0);
    mem_read = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    xfer("post_reset_load_s1", 1'b1, 1'b0, 32'h4000_1020, 32'h0, 2, 32'hCAFE_0123, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
